// File: rtl/yd_pkg.sv
// Shared YD core definitions: interrupt controller FSM states, jump/write opcodes
// and the PC register address, plus sizing helpers used by yd_intc.
package yd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_VECTOR,
    ST_ACTIVE,
    ST_RET
  } intc_state_t;

  localparam logic [3:0] OP_JA       = 4'hA;
  localparam logic [3:0] OP_JW       = 4'hB;
  localparam logic [3:0] PC_REG_ADDR = 4'hF;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Without nesting the save stack collapses to a single register.
  function automatic int stack_depth(input bit nest_en, input int depth);
    return nest_en ? ((depth > 0) ? depth : 1) : 1;
  endfunction

endpackage

// File: rtl/yd_intc_prio.sv
// Lowest-index-wins priority encoder: reports whether any request is set and
// the index of the lowest set request.
module yd_intc_prio
  import yd_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] id
);

  assign valid = |req;

  // Scanning downwards lets the lowest set index overwrite all higher ones.
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = IW'(i);
    end
  end

endmodule

// File: rtl/yd_intc.sv
// yd_intc: vectored, prioritised interrupt controller for the YD core pipeline.
// Define YD_INTC_NEST_EN to compile in preemptive nesting with a NEST_DEPTH-entry save stack.
module yd_intc
  import yd_pkg::*;
#(
  parameter int            N_SRC      = 4,
  parameter int            PW         = 16,
  parameter logic [PW-1:0] VEC_BASE   = 16'hFF00,
  parameter int            VEC_STRIDE = 4,
  parameter int            NEST_DEPTH = 2,
  localparam int           IW         = id_width(N_SRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic [PW-1:0]    pc,
  input  logic             jpc,
  input  logic             dwi,
  input  logic             iret,
  output logic             int_rdy,
  output logic             inp,
  output logic             pc_we,
  output logic [PW-1:0]    pc_din,
  output logic [PW-1:0]    epc,
  output logic             int_act,
  output logic [IW-1:0]    int_id
);

`ifdef YD_INTC_NEST_EN
  localparam bit NEST_ON = 1'b1;
`else
  localparam bit NEST_ON = 1'b0;
`endif
  localparam int SD = stack_depth(NEST_ON, NEST_DEPTH);
  localparam int DW = $clog2(SD + 1);
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;

  intc_state_t      state, state_n;
  logic [N_SRC-1:0] pend, elig, clr;
  logic [PW-1:0]    stk_pc [SD];
  logic [IW-1:0]    stk_id [SD];
  logic [DW-1:0]    depth;
  logic [AW-1:0]    top, push_idx;
  logic [PW-1:0]    vec_addr;
  logic             hazard, stk_full;
  logic             win_valid, pre_valid, sel_valid;
  logic [IW-1:0]    win_id, pre_id, sel_id;

  assign elig     = pend & irq_mask;
  assign hazard   = jpc | dwi;
  assign top      = AW'(depth - DW'(1));
  assign push_idx = AW'(depth);
  assign stk_full = (depth == DW'(SD));
  assign vec_addr = VEC_BASE + PW'(int_id) * PW'(VEC_STRIDE);

  yd_intc_prio #(.N(N_SRC), .IW(IW)) u_prio (
    .req   (elig),
    .valid (win_valid),
    .id    (win_id)
  );

`ifdef YD_INTC_NEST_EN
  // Only sources strictly more urgent than the running handler may preempt it.
  logic [N_SRC-1:0] hi_mask;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      hi_mask[i] = (i < int'(int_id));
    end
  end

  yd_intc_prio #(.N(N_SRC), .IW(IW)) u_prio_pre (
    .req   (elig & hi_mask),
    .valid (pre_valid),
    .id    (pre_id)
  );
`else
  assign pre_valid = 1'b0;
  assign pre_id    = '0;
`endif

  // From IDLE any eligible source may win; inside a handler only a preempting one.
  assign sel_valid = (depth == '0) ? win_valid : pre_valid;
  assign sel_id    = (depth == '0) ? win_id    : pre_id;
  assign clr       = (state == ST_FLUSH && sel_valid) ? (N_SRC'(1) << sel_id) : '0;

  assign epc     = (depth != '0) ? stk_pc[top] : '0;
  assign int_id  = (depth != '0) ? stk_id[top] : '0;
  assign int_act = (depth != '0);
  assign int_rdy = (state == ST_IDLE) && !hazard;

  always_comb begin
    state_n = state;
    inp     = 1'b0;
    pc_we   = 1'b0;
    pc_din  = '0;
    case (state)
      ST_IDLE: begin
        if (win_valid && !hazard) state_n = ST_FLUSH;
      end
      ST_FLUSH: begin
        inp = 1'b1;
        if (sel_valid)          state_n = ST_VECTOR;
        else if (depth == '0)   state_n = ST_IDLE;
        else                    state_n = ST_ACTIVE;
      end
      ST_VECTOR: begin
        pc_we   = 1'b1;
        pc_din  = vec_addr;
        state_n = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (iret)                                          state_n = ST_RET;
        else if (NEST_ON && pre_valid && !hazard && !stk_full) state_n = ST_FLUSH;
      end
      ST_RET: begin
        pc_we   = 1'b1;
        pc_din  = epc;
        state_n = (depth > DW'(1)) ? ST_ACTIVE : ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // New requests are OR-ed in after the entry clear so a colliding pulse survives.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      pend  <= '0;
      depth <= '0;
      for (int i = 0; i < SD; i++) begin
        stk_pc[i] <= '0;
        stk_id[i] <= '0;
      end
    end else begin
      state <= state_n;
      pend  <= (pend & ~clr) | irq;
      if (state == ST_FLUSH && sel_valid) begin
        stk_pc[push_idx] <= pc;
        stk_id[push_idx] <= sel_id;
        depth            <= depth + DW'(1);
      end else if (state == ST_RET) begin
        depth <= depth - DW'(1);
      end
    end
  end

endmodule
